// File: rtl/alu_cap_pkg.sv
// Shared definitions for the ALU result capture path: FSM state encoding
// and the layout of a captured word {CF, GZ, res}.
package alu_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int RES_W  = 7;
  localparam int WORD_W = 9;
  localparam int CF_BIT = 8;
  localparam int GZ_BIT = 7;

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO. The head word is driven straight from the
// storage array so a word written on one edge is readable the next cycle.
// A push into a full FIFO is accepted only when a pop frees a slot on the
// same edge; a pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_V);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage write; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/alu_result_capture.sv
// Observation path for the ALU result stream. A start pulse arms a window
// of CAP_LEN samples; each sample is queued for a valid/ready reader and
// tallied into saturating CF/GZ counters. Samples that find the queue full
// are still counted but dropped, which latches the sticky overflow flag.
module alu_result_capture
  import alu_cap_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CAP_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              res_valid,
  input  logic [6:0]        res,
  input  logic              CF,
  input  logic              GZ,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [8:0]        rd_data,
  output logic [CNT_W-1:0]  cf_cnt,
  output logic [CNT_W-1:0]  gz_cnt,
  output logic              overflow,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0]       CAP_LEN_V = 8'(CAP_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t             state_reg;
  state_t             state_next;
  logic [7:0]         sample_cnt_reg;
  logic [7:0]         sample_cnt_inc;
  logic [CNT_W-1:0]   cf_cnt_reg;
  logic [CNT_W-1:0]   gz_cnt_reg;
  logic               overflow_reg;
  logic               sampling;
  logic               start_accept;
  logic               pop_fire;
  logic               fifo_full;
  logic               fifo_empty;
  logic [WORD_W-1:0]  word;

  assign sampling       = ((state_reg == ARMED) || (state_reg == CAPTURE)) && res_valid;
  assign start_accept   = (state_reg == IDLE) && start;
  assign pop_fire       = rd_valid && rd_ready;
  assign sample_cnt_inc = sample_cnt_reg + 8'd1;
  assign rd_valid       = !fifo_empty;
  assign cf_cnt         = cf_cnt_reg;
  assign gz_cnt         = gz_cnt_reg;
  assign overflow       = overflow_reg;

  // Pack the captured word from the package field positions.
  always_comb begin
    word                = '0;
    word[CF_BIT]        = CF;
    word[GZ_BIT]        = GZ;
    word[RES_W-1:0]     = res;
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sampling),
    .pop   (pop_fire),
    .din   (word),
    .dout  (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and status outputs; the window ends on the CAP_LEN-th sample.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = ARMED;
      end
      ARMED, CAPTURE: begin
        busy = 1'b1;
        if (res_valid)
          state_next = (sample_cnt_inc == CAP_LEN_V) ? DONE : CAPTURE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Window statistics: cleared on an accepted start, updated per sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_reg <= '0;
      cf_cnt_reg     <= '0;
      gz_cnt_reg     <= '0;
      overflow_reg   <= 1'b0;
    end else if (start_accept) begin
      sample_cnt_reg <= '0;
      cf_cnt_reg     <= '0;
      gz_cnt_reg     <= '0;
      overflow_reg   <= 1'b0;
    end else if (sampling) begin
      sample_cnt_reg <= sample_cnt_inc;
      if (CF && (cf_cnt_reg != CNT_MAX)) cf_cnt_reg <= cf_cnt_reg + CNT_W'(1);
      if (GZ && (gz_cnt_reg != CNT_MAX)) gz_cnt_reg <= gz_cnt_reg + CNT_W'(1);
      if (fifo_full && !pop_fire) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed bench for alu_result_capture. Two instances share stimulus:
// dut_a (CAP_LEN=3, CNT_W=8) for the basic window, dut_b (DEPTH=4,
// CAP_LEN=6, CNT_W=2) for overflow, full push/pop, gaps and saturation.
// Every scenario begins with a reset so each instance starts from IDLE.
module tb_alu_result_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       res_valid;
  logic [6:0] res;
  logic       CF;
  logic       GZ;
  logic       rd_ready;

  logic       rd_valid_a, overflow_a, busy_a, done_a;
  logic [8:0] rd_data_a;
  logic [7:0] cf_cnt_a, gz_cnt_a;

  logic       rd_valid_b, overflow_b, busy_b, done_b;
  logic [8:0] rd_data_b;
  logic [1:0] cf_cnt_b, gz_cnt_b;

  int tests  = 0;
  int errors = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int d0;

  always #5 clk = ~clk;

  alu_result_capture #(.DEPTH(4), .CAP_LEN(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res(res),
    .CF(CF), .GZ(GZ), .rd_valid(rd_valid_a), .rd_ready(rd_ready),
    .rd_data(rd_data_a), .cf_cnt(cf_cnt_a), .gz_cnt(gz_cnt_a),
    .overflow(overflow_a), .busy(busy_a), .done(done_a)
  );

  alu_result_capture #(.DEPTH(4), .CAP_LEN(6), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res(res),
    .CF(CF), .GZ(GZ), .rd_valid(rd_valid_b), .rd_ready(rd_ready),
    .rd_data(rd_data_b), .cf_cnt(cf_cnt_b), .gz_cnt(gz_cnt_b),
    .overflow(overflow_b), .busy(busy_b), .done(done_b)
  );

  // Count done pulses away from the active edge.
  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; res_valid = 0; res = '0; CF = 0; GZ = 0; rd_ready = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [6:0] r, input logic c, input logic g);
    res = r; CF = c; GZ = g; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; start = 0; res_valid = 0; res = '0; CF = 0; GZ = 0; rd_ready = 0;
    #2;
    rst = 1'b0;
    step();

    // 1. Asynchronous reset mid-cycle after some activity, then quiet cycles.
    pulse_start();
    send(7'd3, 1'b1, 1'b1);
    send(7'd4, 1'b1, 1'b1);
    check("t1 pre busy", busy_b, 1);
    check("t1 pre cf", cf_cnt_b, 2);
    d0 = done_cnt_b;
    #2;
    rst = 1'b1;
    #1;
    check("t1 rd_valid", rd_valid_b, 0);
    check("t1 rd_data", rd_data_b, 0);
    check("t1 cf_cnt", cf_cnt_b, 0);
    check("t1 gz_cnt", gz_cnt_b, 0);
    check("t1 overflow", overflow_b, 0);
    check("t1 busy", busy_b, 0);
    rst = 1'b0;
    idle(5);
    check("t1 idle rd_valid", rd_valid_b, 0);
    check("t1 idle busy", busy_b, 0);
    check("t1 idle cf_cnt", cf_cnt_b, 0);
    check("t1 no done", done_cnt_b - d0, 0);

    // 2. Basic window on dut_a (CAP_LEN=3), reader always ready.
    do_reset();
    rd_ready = 1'b1;
    d0 = done_cnt_a;
    pulse_start();
    check("t2 busy armed", busy_a, 1);
    send(7'd5, 1'b0, 1'b1);
    check("t2 word0", rd_data_a, 9'h085);
    send(7'd0, 1'b1, 1'b0);
    check("t2 word1", rd_data_a, 9'h100);
    send(7'd127, 1'b1, 1'b1);
    check("t2 word2", rd_data_a, 9'h1FF);
    check("t2 done", done_a, 1);
    check("t2 busy with done", busy_a, 0);
    check("t2 cf_cnt", cf_cnt_a, 2);
    check("t2 gz_cnt", gz_cnt_a, 2);
    step();
    check("t2 done low", done_a, 0);
    check("t2 empty", rd_valid_a, 0);
    check("t2 one done", done_cnt_a - d0, 1);

    // 3. Overflow on dut_b: 6 samples, reader stalled, then drain.
    do_reset();
    pulse_start();
    for (int i = 1; i <= 6; i++) begin
      send(7'(i), 1'b0, 1'b0);
      if (i == 4) check("t3 no ovf at 4", overflow_b, 0);
    end
    check("t3 overflow", overflow_b, 1);
    check("t3 done", done_b, 1);
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t3 drain valid", rd_valid_b, 1);
      check("t3 drain data", rd_data_b, 32'(i));
      step();
    end
    check("t3 drained", rd_valid_b, 0);
    check("t3 ovf sticky", overflow_b, 1);

    // 4. Full FIFO with simultaneous push and pop.
    do_reset();
    pulse_start();
    for (int i = 1; i <= 4; i++) send(7'(i), 1'b0, 1'b0);
    check("t4 full head", rd_data_b, 1);
    rd_ready = 1'b1;
    send(7'd5, 1'b0, 1'b0);
    check("t4 no overflow", overflow_b, 0);
    for (int i = 2; i <= 5; i++) begin
      check("t4 order valid", rd_valid_b, 1);
      check("t4 order data", rd_data_b, 32'(i));
      step();
    end
    check("t4 count four", rd_valid_b, 0);

    // 5/6. Ignore rules, gaps, start during capture, CF saturation.
    do_reset();
    d0 = done_cnt_b;
    send(7'd9, 1'b1, 1'b1);
    check("t5 idle no push", rd_valid_b, 0);
    check("t5 idle no count", cf_cnt_b, 0);
    pulse_start();
    send(7'd10, 1'b1, 1'b0);
    idle(3);
    check("t5 gap cf", cf_cnt_b, 1);
    check("t5 gap busy", busy_b, 1);
    pulse_start();
    check("t5 start ignored", cf_cnt_b, 1);
    for (int i = 11; i <= 14; i++) begin
      send(7'(i), 1'b1, 1'b0);
      idle(1);
    end
    check("t6 cf saturated", cf_cnt_b, 3);
    check("t5 not done at 5", done_cnt_b - d0, 0);
    send(7'd15, 1'b0, 1'b0);
    check("t5 done at 6", done_b, 1);
    check("t5 gz_cnt", gz_cnt_b, 0);
    rd_ready = 1'b1;
    for (int i = 10; i <= 13; i++) begin
      check("t5 drain data", rd_data_b, 32'(9'h100 | i));
      step();
    end
    check("t5 drained", rd_valid_b, 0);

    // 6. Reset pulse mid-window after 2 of 4 samples.
    do_reset();
    d0 = done_cnt_b;
    pulse_start();
    send(7'd21, 1'b0, 1'b1);
    send(7'd22, 1'b0, 1'b1);
    check("t6 pre rd_valid", rd_valid_b, 1);
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    check("t6 fifo empty", rd_valid_b, 0);
    check("t6 idle", busy_b, 0);
    send(7'd23, 1'b0, 1'b1);
    send(7'd24, 1'b0, 1'b1);
    idle(3);
    check("t6 no push after rst", rd_valid_b, 0);
    check("t6 no done", done_cnt_b - d0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_capture.md
Name: alu_result_capture

Overview:
- Receive-side block for the FSM/ALU result stream: res, CF and GZ.
- Captures a bounded window of results into a small FIFO when armed.
- Keeps saturating CF/GZ event counts and flags dropped samples.
- Presents captured words to a downstream reader over a valid/ready handshake.
- Sits beside Top, on its result outputs, as the observation/readback path for silicon bring-up.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- CAP_LEN, 8: results captured per armed window; range 1..255.
- CNT_W, 8: width of the CF/GZ event counters.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle pulse; arms a capture window.
- res_valid  input  1  res/CF/GZ valid this cycle.
- res  input  7  ALU result.
- CF  input  1  carry flag qualified with res.
- GZ  input  1  greater-than-zero flag qualified with res.
- rd_valid  output  1  FIFO non-empty.
- rd_ready  input  1  reader accepts the head word.
- rd_data  output  9  head word: {CF, GZ, res[6:0]}.
- cf_cnt  output  CNT_W  captured samples with CF=1, saturating.
- gz_cnt  output  CNT_W  captured samples with GZ=1, saturating.
- overflow  output  1  sticky; a sample was dropped because the FIFO was full.
- busy  output  1  state is ARMED or CAPTURE.
- done  output  1  one-cycle pulse when the window completes.

Behaviour:
Reset:
- rst high clears, asynchronously, all of: state=IDLE, FIFO pointers and count, cf_cnt, gz_cnt, sample counter, overflow, done.
- Resulting outputs: rd_valid=0, rd_data=0, busy=0.
- rst asserted mid-window discards FIFO contents; no done pulse is produced.

State machine:
- IDLE: start -> ARMED. Counters, overflow and sample count clear on that edge. FIFO contents are kept.
- ARMED: the first cycle with res_valid=1 is sample 0 and is captured on that edge. Next state is CAPTURE, or DONE if CAP_LEN=1.
- CAPTURE: each res_valid cycle is one sample. When the sample count reaches CAP_LEN, the next state is DONE.
- DONE: done=1 for exactly this one cycle; next state IDLE.
- start is ignored outside IDLE.

Capture rules:
- A sample is pushed when (ARMED or CAPTURE) and res_valid and FIFO not full.
- A sample arriving while the FIFO is full is not stored. It still counts toward CAP_LEN and toward cf_cnt/gz_cnt. It sets overflow.
- overflow clears only on rst or on start accepted in IDLE.
- res_valid in IDLE or DONE is ignored.
- cf_cnt increments by 1 per sample with CF=1; gz_cnt likewise for GZ=1. Both hold at 2^CNT_W-1.

FIFO:
- Registered storage. rd_data is the head word and is valid whenever rd_valid=1; it is 0 when empty.
- Pop occurs when rd_valid and rd_ready.
- Push and pop in the same cycle while full: the pop frees space, so the push is accepted; count is unchanged and there is no overflow.
- Push and pop in the same cycle while empty: only the push takes effect.
- Pointers wrap modulo DEPTH.
- Latency: a sample pushed at edge N is visible on rd_data after edge N, i.e. rd_valid is high in cycle N+1.

Decomposition:
- Package alu_cap_pkg holds:
  - state encoding: IDLE=2'd0, ARMED=2'd1, CAPTURE=2'd2, DONE=2'd3;
  - RES_W=7;
  - WORD_W=9;
  - field positions CF_BIT=8, GZ_BIT=7.
- Sub-module sync_fifo (WIDTH, DEPTH; ports push, pop, din, dout, full, empty) holds the storage.
- alu_result_capture contains the FSM, counters and overflow logic.

Test Plan:
1. Reset: assert rst async mid-cycle -> outputs immediately rd_valid=0, cf_cnt=0, gz_cnt=0, overflow=0, busy=0; release, no activity for 5 cycles -> all outputs unchanged.
2. Basic window, CAP_LEN=3: start, then valid samples {res=5,CF=0,GZ=1}, {res=0,CF=1,GZ=0}, {res=127,CF=1,GZ=1} with rd_ready=1 -> rd_data sequence 0x085, 0x100, 0x1FF; cf_cnt=2, gz_cnt=2; done pulses once, 1 cycle after the third sample; busy falls with done.
3. Overflow, DEPTH=4, CAP_LEN=6, rd_ready=0: 6 valid samples res=1..6 -> FIFO holds 1..4, overflow=1, done pulses; then drain -> exactly 4 words, res 1,2,3,4.
4. Full with simultaneous push/pop: FIFO full, rd_ready=1 and res_valid=1 in the same cycle -> no overflow, count stays 4, order preserved.
5. Gaps and ignore rules: samples with res_valid low for 3 cycles between valids -> gaps not counted. start during CAPTURE -> ignored. res_valid in IDLE -> no push.
6. Saturation and mid-window reset: CNT_W=2, 5 samples with CF=1 -> cf_cnt=3. rst pulse after 2 of 4 samples -> FIFO empty, state IDLE, no done pulse.
